i2c_slave_responder: RTL
========================

// Module: i2c_slave_responder
// PURPOSE
// - Synthesizable I2C target (responder) answering the iicmb_m_wb controller on one I2C bus; RTL replacement for the behavioural slave BFM.
// - Decodes START/STOP, matches a 7-bit address, streams written bytes out on rx_*, and takes read bytes from tx_*.
// - Open-drain; the bus resolves through triand/tri1 nets. Fully oversampled by clk_i; no clock stretching.
// PARAMETERS
// - SLAVE_ADDR   7'h22  7-bit address this target acknowledges
// - DATA_WIDTH   8      byte width; fixed at 8, other values illegal
// - SYNC_STAGES  2      synchronizer depth on scl_i/sda_i (>=2)
// PORTS
// - clk_i       in   1  system clock; only clock
// - rst_i       in   1  synchronous, active-low reset
// - scl_i       in   1  I2C clock from bus
// - sda_i       in   1  I2C data from bus
// - scl_o       out  1  constant 1 (released); no stretching
// - sda_o       out  1  0 = pull low, 1 = release
// - rx_data_o   out  8  last byte written by the master
// - rx_valid_o  out  1  1-cycle pulse; rx_data_o valid
// - tx_data_i   in   8  next byte to return on a read
// - tx_valid_i  in   1  tx_data_i holds a byte
// - tx_ready_o  out  1  1-cycle pulse; tx_data_i consumed this cycle
// - start_o     out  1  1-cycle pulse per START or repeated START
// - stop_o      out  1  1-cycle pulse per STOP
// - busy_o      out  1  1 from START to STOP
// - rd_o        out  1  R/W bit of the current transfer (1 = read)
// BEHAVIOUR
// - Reset (rst_i=0 at a clk_i edge): state IDLE. All outputs 0 except sda_o=1 and scl_o=1. Shift register and bit counter cleared.
// - Sync: SYNC_STAGES flops, then one more flop for edge detect. Every bus event is recognised SYNC_STAGES+1 clk_i cycles after the pin changes.
// - START: sda fall while scl=1, in any state -> ADDR; bit count=0; start_o pulse; busy_o=1. Repeated START is the same event.
// - STOP: sda rise while scl=1, in any state -> IDLE; sda_o=1; stop_o pulse; busy_o=0. STOP takes priority over every other event in that cycle.
// - Sampling: sda is shifted in MSB first on each scl rise. sda_o changes only on a detected scl fall.
// - States and transitions:
//   - IDLE: ignores scl edges.
//   - ADDR: 8 bits. Address match -> ADDR_ACK (sda_o=0 at the next fall); latch rd_o. No match -> IDLE until the next START.
//   - ADDR_ACK: release at the fall after the 9th clock. If rd_o=0 -> WR_BYTE. If rd_o=1 -> load the first read byte -> RD_BYTE.
//   - WR_BYTE: 8 bits. On the 8th rise: rx_data_o <= shift, rx_valid_o pulse. -> WR_ACK (always ACK).
//   - WR_ACK: release at the next fall -> WR_BYTE.
//   - RD_BYTE: drive the MSB at the fall that enters the state, next bits at each following fall. After 8 bits, release -> RD_ACK.
//   - RD_ACK: sample sda on the 9th rise. 0 (ACK) -> load the next byte -> RD_BYTE. 1 (NACK) -> IDLE, sda released.
// - Read byte load: done in the cycle the state is entered. If tx_valid_i=1: use tx_data_i and pulse tx_ready_o. Otherwise send 8'hFF with no tx_ready_o pulse.
// - The bit counter wraps 7->0 every byte; transfer length is unbounded.
// - START or STOP in the middle of a byte aborts it: no rx_valid_o, no tx_ready_o, sda released the next cycle.
// - Reset in the middle of a transfer releases sda within 1 cycle. The master then sees NACK or 1-bits.
// STRUCTURE
// - Package i2c_pkg: i2c_state_t enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK); I2C_ADDR_WIDTH=7; I2C_DATA_WIDTH=8. Shared with the i2c_if BFM.
// - Sub-module i2c_bus_sync: synchronizer plus edge detect. Outputs scl_rise, scl_fall, start_det, stop_det.
// - Top: FSM, shift register, bit counter, output regs. About 200 lines.
// TESTING
// - Bench drives the DUT through iicmb_m_wb with the wb_if master; SLAVE_ADDR=7'h22; checkers on rx_*, tx_*, start_o/stop_o.
// - Write: START, 0x44, bytes 0..31, STOP -> 32 rx_valid_o pulses with rx_data_o=0..31, all ACKed; then start_o and stop_o once each.
// - Read: START, 0x45, tx_data_i=100+i, 31 read-ACK, 1 read-NACK, STOP -> DPR reads 100..131; 32 tx_ready_o pulses; FSM in IDLE after the NACK.
// - Wrong address: START, 0x46 -> CMDR NAK bit set; no rx_valid_o or tx_ready_o; sda_o stays 1.
// - Repeated START: write 0x44, byte 0xA5, then START, 0x45 (no STOP) -> rx 0xA5; rd_o goes 0->1; two start_o pulses.
// - Underflow: read with tx_valid_i=0 -> DPR reads 0xFF; no tx_ready_o pulse.
// - Reset mid-read: assert rst_i low while sda_o=0 -> sda_o=1 the next cycle; the next transfer completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, bus widths and small helpers.
// Also imported by the i2c_if BFM so both sides agree on state names.
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6
  } i2c_state_t;

  function automatic logic addr_match(
    input logic [I2C_ADDR_WIDTH-1:0] rx_addr,
    input logic [I2C_ADDR_WIDTH-1:0] own_addr
  );
    return rx_addr == own_addr;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk_i and detects scl edges plus START/STOP conditions.
// Bus events appear SYNC_STAGES+1 clk_i edges after the pin changes.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  logic                   scl_s;
  logic                   sda_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
    scl_prev_d = scl_sync_q[SYNC_STAGES-1];
    sda_prev_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Reset to the idle-bus level so leaving reset never fakes a START or STOP.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_s       = scl_sync_q[SYNC_STAGES-1];
  assign sda_s       = sda_sync_q[SYNC_STAGES-1];
  assign sda_s_o     = sda_s;
  assign scl_rise_o  =  scl_s & ~scl_prev_q;
  assign scl_fall_o  = ~scl_s &  scl_prev_q;
  // sda may only move with scl held high on both samples to count as START/STOP.
  assign start_det_o = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
  assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// Oversampled I2C target: address match, write bytes out on rx_*, read bytes from tx_*.
// Open-drain sda_o (0 pulls low), scl never stretched.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h22,
  parameter int                        DATA_WIDTH  = I2C_DATA_WIDTH,
  parameter int                        SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  busy_o,
  output logic                  rd_o
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .sda_s_o     (sda_s),
    .scl_rise_o  (scl_rise),
    .scl_fall_o  (scl_fall),
    .start_det_o (start_det),
    .stop_det_o  (stop_det)
  );

  i2c_state_t            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-2:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  sda_q, sda_d;
  logic                  rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  busy_q, busy_d;

  logic [DATA_WIDTH-1:0] shift_in;
  logic [DATA_WIDTH-1:0] load_byte;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    sda_d      = sda_q;
    rd_d       = rd_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_q;

    shift_in  = {shift_q, sda_s};
    // An empty tx side returns all-ones, which the master reads as an idle bus.
    load_byte = tx_valid_i ? tx_data_i : '1;

    if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      shift_d   = '0;
      sda_d     = 1'b1;
      start_d   = 1'b1;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = shift_in[DATA_WIDTH-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              if (addr_match(shift_in[DATA_WIDTH-1:1], SLAVE_ADDR)) begin
                rd_d    = shift_in[0];
                state_d = ADDR_ACK;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        // First fall pulls sda low for ACK, the second fall ends the ACK clock.
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (sda_q) begin
              sda_d = 1'b0;
            end else if (rd_q) begin
              sda_d      = load_byte[DATA_WIDTH-1];
              tx_shift_d = {load_byte[DATA_WIDTH-2:0], 1'b1};
              tx_ready_d = tx_valid_i;
              state_d    = RD_BYTE;
            end else begin
              sda_d   = 1'b1;
              state_d = WR_BYTE;
            end
          end
        end
        WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = shift_in[DATA_WIDTH-2:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (sda_q) begin
              sda_d = 1'b0;
            end else begin
              sda_d   = 1'b1;
              state_d = WR_BYTE;
            end
          end
        end
        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == LAST_BIT) begin
              sda_d     = 1'b1;
              bit_cnt_d = '0;
              state_d   = RD_ACK;
            end else begin
              sda_d      = tx_shift_q[DATA_WIDTH-1];
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b1};
              bit_cnt_d  = bit_cnt_q + 3'd1;
            end
          end
        end
        // A fall is only reached here after an ACK rise; a NACK rise already left.
        RD_ACK: begin
          if (scl_rise && sda_s) begin
            state_d = IDLE;
          end else if (scl_fall) begin
            sda_d      = load_byte[DATA_WIDTH-1];
            tx_shift_d = {load_byte[DATA_WIDTH-2:0], 1'b1};
            tx_ready_d = tx_valid_i;
            bit_cnt_d  = '0;
            state_d    = RD_BYTE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      sda_q      <= 1'b1;
      rd_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      sda_q      <= sda_d;
      rd_q       <= rd_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  assign scl_o      = 1'b1;
  assign sda_o      = sda_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = tx_ready_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign busy_o     = busy_q;
  assign rd_o       = rd_q;

endmodule
